// File: rtl/valids_expander.sv
// Expands a lane-count request into one or more contiguous valids-mask beats,
// low lanes first, at most PER_BEAT lanes per beat, with valid/ready on both sides.
module valids_expander #(
    parameter int LANES    = 16,
    parameter int CNT_W    = 5,
    parameter int PER_BEAT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] valids,
    output logic             last,
    output logic             err
);

    localparam logic [CNT_W-1:0] LANES_C    = CNT_W'(LANES);
    localparam logic [CNT_W-1:0] PER_BEAT_C = CNT_W'(PER_BEAT);

    typedef enum logic [0:0] {IDLE, ISSUE} state_t;

    state_t           state;
    logic [CNT_W-1:0] rem;

    logic             in_fire;
    logic             out_fire;
    logic [CNT_W-1:0] src;
    logic [CNT_W-1:0] n;
    logic [LANES-1:0] nxt_valids;
    logic             nxt_last;
    logic [CNT_W-1:0] nxt_rem;

    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] x);
        return (x > LANES_C) ? LANES_C : x;
    endfunction

    function automatic logic [CNT_W-1:0] beat_count(input logic [CNT_W-1:0] x);
        return (x > PER_BEAT_C) ? PER_BEAT_C : x;
    endfunction

    // One extra bit so a full LANES-wide mask does not wrap to zero.
    function automatic logic [LANES-1:0] lane_mask(input logic [CNT_W-1:0] cnt);
        logic [LANES:0] one;
        logic [LANES:0] m;
        one = (LANES+1)'(1);
        m   = (one << cnt) - one;
        return m[LANES-1:0];
    endfunction

    assign out_fire = out_valid && out_ready;
    assign in_ready = rst_n && (state == IDLE || (out_fire && last && rem == '0));
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        src        = in_fire ? sat_count(b) : rem;
        n          = beat_count(src);
        nxt_valids = lane_mask(n);
        nxt_last   = (src <= PER_BEAT_C);
        nxt_rem    = src - n;
    end

    // Stage boundary: next beat registered onto the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            out_valid <= 1'b0;
            valids    <= '0;
            last      <= 1'b0;
            err       <= 1'b0;
        end else if (in_fire) begin
            if (b > LANES_C)
                err <= 1'b1;
            state     <= ISSUE;
            out_valid <= 1'b1;
            valids    <= nxt_valids;
            last      <= nxt_last;
            rem       <= nxt_rem;
        end else if (out_fire) begin
            if (!last) begin
                valids <= nxt_valids;
                last   <= nxt_last;
                rem    <= nxt_rem;
            end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                valids    <= '0;
                last      <= 1'b0;
            end
        end
    end

endmodule
